// File: rtl/ric_prio_pkg.sv
// Shared types and sizing for the priority routing interrupt controller.
// Source IDs, priorities and owner-core fields are typed so widths track the sizing.
package ric_prio_pkg;
   localparam int NIRQ        = 32;
   localparam int NCORE       = 4;
   localparam int PRIO_W      = 3;
   localparam int ID_W        = $clog2(NIRQ);
   localparam int CORE_W      = $clog2(NCORE);
   localparam int PLIC_PRIO_W = PRIO_W;

   typedef logic [PLIC_PRIO_W-1:0] plic_intr_prio_t;
   typedef logic [ID_W-1:0]        plic_intr_id_t;
   typedef logic [CORE_W-1:0]      plic_intr_core_id_t;

   typedef enum logic {
      PLIC_LEVEL = 1'b0,
      PLIC_EDGE  = 1'b1
   } plic_intr_mode_t;
endpackage

// File: rtl/ric_prio_gateway.sv
// Per-source gateway: two-flop synchroniser, edge detect, pending and in-service state.
// The claim and complete inputs are one-cycle strobes that are already decoded for this source.
module ric_prio_gateway
   import ric_prio_pkg::*;
(
   input  logic clk,
   input  logic rstn,
   input  logic i_irq,
   input  logic i_edge,
   input  logic i_dbg,
   input  logic i_claim,
   input  logic i_complete,
   output logic o_pending,
   output logic o_in_service
);
   logic [1:0]      r_sync;
   logic            r_req_d;
   logic            r_pending;
   logic            r_in_service;
   logic            w_req_s;
   logic            w_rise;
   logic            w_level;
   logic            w_lvl_req;
   logic            w_free;
   logic            w_pending_nxt;
   plic_intr_mode_t w_mode;

   assign w_mode    = plic_intr_mode_t'(i_edge);
   assign w_req_s   = r_sync[1];
   assign w_rise    = w_req_s & ~r_req_d;
   assign w_level   = (w_mode == PLIC_LEVEL) | i_dbg;
   assign w_lvl_req = w_req_s | i_dbg;
   // A complete in this cycle frees the source, so a held level request re-pends at the same edge.
   assign w_free    = ~r_in_service | i_complete;

   always_comb begin
      w_pending_nxt = r_pending;
      if (w_level) begin
         if (i_claim)
            w_pending_nxt = 1'b0;
         else if (w_free)
            w_pending_nxt = w_lvl_req;
      end else begin
         if (w_rise)
            w_pending_nxt = 1'b1;
         else if (i_claim)
            w_pending_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_sync       <= '0;
         r_req_d      <= 1'b0;
         r_pending    <= 1'b0;
         r_in_service <= 1'b0;
      end else begin
         r_sync       <= {r_sync[0], i_irq};
         r_req_d      <= w_req_s;
         r_pending    <= w_pending_nxt;
         r_in_service <= i_claim | (r_in_service & ~i_complete);
      end
   end

   assign o_pending    = r_pending;
   assign o_in_service = r_in_service;
endmodule

// File: rtl/ric_prio.sv
// Routing interrupt controller: per-source gateways, a per-core priority arbiter
// with threshold, and the claim/complete handshake.
module ric_prio
   import ric_prio_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic               [NIRQ-1:0]        irq_in,
   input  plic_intr_core_id_t [NIRQ-1:0]        s2b_intr_core_id,
   input  logic               [NIRQ-1:0]        s2b_intr_en,
   input  logic               [NIRQ-1:0]        s2b_dbg_en,
   input  logic               [NIRQ-1:0]        s2b_intr_edge,
   input  plic_intr_prio_t    [NIRQ-1:0]        s2b_intr_prio,
   input  plic_intr_prio_t    [NCORE-1:0]       s2b_threshold,
   input  logic               [NCORE-1:0]       claim_req,
   output logic               [NCORE-1:0]       claim_ack,
   output logic               [NCORE-1:0]       claim_valid,
   output plic_intr_id_t      [NCORE-1:0]       claim_id,
   input  logic               [NCORE-1:0]       complete_req,
   input  plic_intr_id_t      [NCORE-1:0]       complete_id,
   output plic_intr_id_t      [NCORE-1:0]       b2s_intr_src,
   output logic               [NCORE-1:0]       external_int,
   output logic               [NIRQ-1:0]        b2s_pending
);
   logic          [NIRQ-1:0]  w_pending;
   logic          [NIRQ-1:0]  w_in_service;
   logic          [NIRQ-1:0]  w_claim_vec;
   logic          [NIRQ-1:0]  w_cmpl_vec;
   logic          [NCORE-1:0] w_win_vld;
   plic_intr_id_t [NCORE-1:0] w_win_id;

   logic          [NCORE-1:0] r_ext;
   plic_intr_id_t [NCORE-1:0] r_src;
   logic          [NCORE-1:0] r_ack;
   logic          [NCORE-1:0] r_cvalid;
   plic_intr_id_t [NCORE-1:0] r_cid;

   // A claim takes the registered winner; several cores completing one ID OR into a single clear.
   always_comb begin
      w_claim_vec = '0;
      w_cmpl_vec  = '0;
      for (int j = 0; j < NIRQ; j++) begin
         for (int i = 0; i < NCORE; i++) begin
            if (claim_req[i] && r_ext[i] && (r_src[i] == ID_W'(j)))
               w_claim_vec[j] = 1'b1;
            if (complete_req[i] && (complete_id[i] == ID_W'(j)))
               w_cmpl_vec[j] = 1'b1;
         end
      end
   end

   for (genvar j = 0; j < NIRQ; j++) begin : g_gw
      ric_prio_gateway u_gw (
         .clk          (clk),
         .rstn         (rstn),
         .i_irq        (irq_in[j]),
         .i_edge       (s2b_intr_edge[j]),
         .i_dbg        (s2b_dbg_en[j]),
         .i_claim      (w_claim_vec[j]),
         .i_complete   (w_cmpl_vec[j]),
         .o_pending    (w_pending[j]),
         .o_in_service (w_in_service[j])
      );
   end

   for (genvar i = 0; i < NCORE; i++) begin : g_arb
      logic            w_found;
      plic_intr_id_t   w_bid;
      plic_intr_prio_t w_bprio;

      // Ascending scan with a strict compare leaves ties with the lowest ID.
      always_comb begin
         w_found = 1'b0;
         w_bid   = '0;
         w_bprio = '0;
         for (int j = 0; j < NIRQ; j++) begin
            if (w_pending[j] && !w_in_service[j] && s2b_intr_en[j] && !w_claim_vec[j] &&
                (s2b_intr_core_id[j] == CORE_W'(i)) &&
                (s2b_intr_prio[j] > s2b_threshold[i]) &&
                (!w_found || (s2b_intr_prio[j] > w_bprio))) begin
               w_found = 1'b1;
               w_bid   = ID_W'(j);
               w_bprio = s2b_intr_prio[j];
            end
         end
      end

      assign w_win_vld[i] = w_found;
      assign w_win_id[i]  = w_bid;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_ext    <= '0;
         r_src    <= '0;
         r_ack    <= '0;
         r_cvalid <= '0;
         r_cid    <= '0;
      end else begin
         r_ext    <= w_win_vld;
         r_src    <= w_win_id;
         r_ack    <= claim_req;
         r_cvalid <= claim_req & r_ext;
         for (int i = 0; i < NCORE; i++)
            r_cid[i] <= (claim_req[i] && r_ext[i]) ? r_src[i] : '0;
      end
   end

   assign external_int = r_ext;
   assign b2s_intr_src = r_src;
   assign claim_ack    = r_ack;
   assign claim_valid  = r_cvalid;
   assign claim_id     = r_cid;
   assign b2s_pending  = w_pending;
endmodule

// File: tb/tb_ric_prio.sv
// Directed bench for ric_prio: level/edge gateways, priority and threshold arbitration,
// claim/complete handshake and asynchronous reset.
module tb_ric_prio;
   import ric_prio_pkg::*;

   logic                               clk;
   logic                               rstn;
   logic               [NIRQ-1:0]      irq_in;
   plic_intr_core_id_t [NIRQ-1:0]      s2b_intr_core_id;
   logic               [NIRQ-1:0]      s2b_intr_en;
   logic               [NIRQ-1:0]      s2b_dbg_en;
   logic               [NIRQ-1:0]      s2b_intr_edge;
   plic_intr_prio_t    [NIRQ-1:0]      s2b_intr_prio;
   plic_intr_prio_t    [NCORE-1:0]     s2b_threshold;
   logic               [NCORE-1:0]     claim_req;
   logic               [NCORE-1:0]     claim_ack;
   logic               [NCORE-1:0]     claim_valid;
   plic_intr_id_t      [NCORE-1:0]     claim_id;
   logic               [NCORE-1:0]     complete_req;
   plic_intr_id_t      [NCORE-1:0]     complete_id;
   plic_intr_id_t      [NCORE-1:0]     b2s_intr_src;
   logic               [NCORE-1:0]     external_int;
   logic               [NIRQ-1:0]      b2s_pending;

   int checks = 0;
   int errors = 0;

   ric_prio dut (
      .clk              (clk),
      .rstn             (rstn),
      .irq_in           (irq_in),
      .s2b_intr_core_id (s2b_intr_core_id),
      .s2b_intr_en      (s2b_intr_en),
      .s2b_dbg_en       (s2b_dbg_en),
      .s2b_intr_edge    (s2b_intr_edge),
      .s2b_intr_prio    (s2b_intr_prio),
      .s2b_threshold    (s2b_threshold),
      .claim_req        (claim_req),
      .claim_ack        (claim_ack),
      .claim_valid      (claim_valid),
      .claim_id         (claim_id),
      .complete_req     (complete_req),
      .complete_id      (complete_id),
      .b2s_intr_src     (b2s_intr_src),
      .external_int     (external_int),
      .b2s_pending      (b2s_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      step(2);
      checks++; if (external_int !== 4'h0) begin errors++; $display("FAIL reset_ext got %h exp 0", external_int); end
      checks++; if (b2s_pending !== 32'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", b2s_pending); end
      checks++; if ({claim_ack, claim_valid} !== 8'h0) begin errors++; $display("FAIL reset_claim got %h exp 0", {claim_ack, claim_valid}); end
      checks++; if ({b2s_intr_src, claim_id} !== 40'h0) begin errors++; $display("FAIL reset_ids got %h exp 0", {b2s_intr_src, claim_id}); end
      rstn = 1'b1;
      step(2);
   endtask

   task automatic test_level_claim();
      s2b_intr_en[5] = 1'b1; s2b_intr_prio[5] = 3'd3; s2b_intr_core_id[5] = 2'd2; s2b_threshold[2] = 3'd1;
      irq_in[5] = 1'b1;
      step(2);
      checks++; if (external_int[2] !== 1'b0) begin errors++; $display("FAIL lvl_sync_early got %b exp 0", external_int[2]); end
      step(2);
      checks++; if (external_int[2] !== 1'b1) begin errors++; $display("FAIL lvl_raise got %b exp 1", external_int[2]); end
      checks++; if (b2s_intr_src[2] !== 5'd5) begin errors++; $display("FAIL lvl_src got %0d exp 5", b2s_intr_src[2]); end
      claim_req[2] = 1'b1;
      step(1);
      claim_req[2] = 1'b0;
      checks++; if ({claim_ack[2], claim_valid[2]} !== 2'b11) begin errors++; $display("FAIL lvl_claim_ack got %b exp 11", {claim_ack[2], claim_valid[2]}); end
      checks++; if (claim_id[2] !== 5'd5) begin errors++; $display("FAIL lvl_claim_id got %0d exp 5", claim_id[2]); end
      checks++; if (external_int[2] !== 1'b0) begin errors++; $display("FAIL lvl_ext_after_claim got %b exp 0", external_int[2]); end
      step(1);
      checks++; if ({claim_ack[2], external_int[2], b2s_intr_src[2]} !== 7'h0) begin errors++; $display("FAIL lvl_held got %h exp 0", {claim_ack[2], external_int[2], b2s_intr_src[2]}); end
      complete_req[2] = 1'b1; complete_id[2] = 5'd5;
      step(1);
      complete_req[2] = 1'b0;
      checks++; if (external_int[2] !== 1'b0) begin errors++; $display("FAIL lvl_cmpl_early got %b exp 0", external_int[2]); end
      step(1);
      checks++; if ({external_int[2], b2s_intr_src[2]} !== {1'b1, 5'd5}) begin errors++; $display("FAIL lvl_reassert got %h exp 25", {external_int[2], b2s_intr_src[2]}); end
      irq_in[5] = 1'b0; s2b_intr_en[5] = 1'b0;
      step(5);
      checks++; if (b2s_pending[5] !== 1'b0) begin errors++; $display("FAIL lvl_drop_pending got %b exp 0", b2s_pending[5]); end
   endtask

   task automatic test_priority();
      s2b_intr_en[3] = 1'b1; s2b_intr_prio[3] = 3'd2;
      s2b_intr_en[7] = 1'b1; s2b_intr_prio[7] = 3'd6;
      irq_in[3] = 1'b1; irq_in[7] = 1'b1;
      step(5);
      checks++; if ({external_int[0], b2s_intr_src[0]} !== {1'b1, 5'd7}) begin errors++; $display("FAIL prio_high got %h exp 27", {external_int[0], b2s_intr_src[0]}); end
      s2b_intr_prio[3] = 3'd4; s2b_intr_prio[7] = 3'd4;
      step(1);
      checks++; if ({external_int[0], b2s_intr_src[0]} !== {1'b1, 5'd3}) begin errors++; $display("FAIL prio_tie got %h exp 23", {external_int[0], b2s_intr_src[0]}); end
      s2b_intr_en[3] = 1'b0; s2b_intr_en[7] = 1'b0; irq_in[3] = 1'b0; irq_in[7] = 1'b0;
      s2b_intr_prio[3] = 3'd0; s2b_intr_prio[7] = 3'd0;
      step(5);
      checks++; if (external_int[0] !== 1'b0) begin errors++; $display("FAIL prio_clear got %b exp 0", external_int[0]); end
   endtask

   task automatic test_threshold();
      s2b_intr_en[11] = 1'b1; s2b_intr_prio[11] = 3'd4; s2b_intr_core_id[11] = 2'd1; s2b_threshold[1] = 3'd4;
      irq_in[11] = 1'b1;
      step(5);
      checks++; if ({b2s_pending[11], external_int[1]} !== 2'b10) begin errors++; $display("FAIL thr_block got %b exp 10", {b2s_pending[11], external_int[1]}); end
      s2b_threshold[1] = 3'd3;
      step(1);
      checks++; if ({external_int[1], b2s_intr_src[1]} !== {1'b1, 5'd11}) begin errors++; $display("FAIL thr_lower got %h exp 2b", {external_int[1], b2s_intr_src[1]}); end
      s2b_intr_en[11] = 1'b0; irq_in[11] = 1'b0;
      step(5);
   endtask

   task automatic test_edge();
      s2b_intr_edge[9] = 1'b1; s2b_intr_en[9] = 1'b1; s2b_intr_prio[9] = 3'd5;
      irq_in[9] = 1'b1;
      step(3);
      irq_in[9] = 1'b0;
      checks++; if ({b2s_pending[9], external_int[0]} !== 2'b10) begin errors++; $display("FAIL edge_pend got %b exp 10", {b2s_pending[9], external_int[0]}); end
      step(1);
      checks++; if ({external_int[0], b2s_intr_src[0]} !== {1'b1, 5'd9}) begin errors++; $display("FAIL edge_raise got %h exp 29", {external_int[0], b2s_intr_src[0]}); end
      step(3);
      checks++; if (b2s_pending[9] !== 1'b1) begin errors++; $display("FAIL edge_hold got %b exp 1", b2s_pending[9]); end
      claim_req[0] = 1'b1;
      step(1);
      claim_req[0] = 1'b0;
      checks++; if ({claim_valid[0], claim_id[0], external_int[0], b2s_pending[9]} !== {1'b1, 5'd9, 2'b00}) begin errors++; $display("FAIL edge_claim got %h exp %h", {claim_valid[0], claim_id[0], external_int[0], b2s_pending[9]}, {1'b1, 5'd9, 2'b00}); end
      for (int p = 0; p < 2; p++) begin
         irq_in[9] = 1'b1;
         step(3);
         irq_in[9] = 1'b0;
         step(3);
         checks++; if ({b2s_pending[9], external_int[0]} !== 2'b10) begin errors++; $display("FAIL edge_in_service_pulse%0d got %b exp 10", p, {b2s_pending[9], external_int[0]}); end
      end
      complete_req[0] = 1'b1; complete_id[0] = 5'd9;
      step(1);
      complete_req[0] = 1'b0;
      checks++; if (external_int[0] !== 1'b0) begin errors++; $display("FAIL edge_cmpl_early got %b exp 0", external_int[0]); end
      step(1);
      checks++; if ({external_int[0], b2s_intr_src[0]} !== {1'b1, 5'd9}) begin errors++; $display("FAIL edge_after_cmpl got %h exp 29", {external_int[0], b2s_intr_src[0]}); end
      claim_req[0] = 1'b1;
      step(1);
      claim_req[0] = 1'b0;
      checks++; if ({claim_valid[0], claim_id[0]} !== {1'b1, 5'd9}) begin errors++; $display("FAIL edge_claim2 got %h exp 29", {claim_valid[0], claim_id[0]}); end
      step(1);
      checks++; if ({b2s_pending[9], external_int[0]} !== 2'b00) begin errors++; $display("FAIL edge_one_deep got %b exp 00", {b2s_pending[9], external_int[0]}); end
      complete_req[0] = 1'b1; complete_id[0] = 5'd9;
      step(1);
      complete_req[0] = 1'b0;
      step(2);
      checks++; if (external_int[0] !== 1'b0) begin errors++; $display("FAIL edge_idle got %b exp 0", external_int[0]); end
      s2b_intr_en[9] = 1'b0; s2b_intr_edge[9] = 1'b0;
   endtask

   task automatic test_empty_claim_and_dbg();
      claim_req[3] = 1'b1;
      step(1);
      claim_req[3] = 1'b0;
      checks++; if ({claim_ack[3], claim_valid[3], claim_id[3]} !== {2'b10, 5'd0}) begin errors++; $display("FAIL empty_claim got %h exp 40", {claim_ack[3], claim_valid[3], claim_id[3]}); end
      s2b_dbg_en[12] = 1'b1; s2b_intr_en[12] = 1'b1; s2b_intr_prio[12] = 3'd2; s2b_intr_core_id[12] = 2'd3;
      step(2);
      checks++; if ({external_int[3], b2s_intr_src[3]} !== {1'b1, 5'd12}) begin errors++; $display("FAIL dbg_raise got %h exp 2c", {external_int[3], b2s_intr_src[3]}); end
      complete_req[3] = 1'b1; complete_id[3] = 5'd12;
      step(1);
      complete_req[3] = 1'b0;
      step(1);
      checks++; if ({b2s_pending[12], external_int[3], b2s_intr_src[3]} !== {2'b11, 5'd12}) begin errors++; $display("FAIL stray_cmpl got %h exp 6c", {b2s_pending[12], external_int[3], b2s_intr_src[3]}); end
      claim_req[3] = 1'b1;
      step(1);
      claim_req[3] = 1'b0;
      checks++; if ({claim_valid[3], claim_id[3], external_int[3]} !== {1'b1, 5'd12, 1'b0}) begin errors++; $display("FAIL dbg_claim got %h exp 58", {claim_valid[3], claim_id[3], external_int[3]}); end
      s2b_dbg_en[12] = 1'b0;
   endtask

   task automatic test_reset_mid_claim();
      s2b_intr_en[5] = 1'b1; s2b_intr_prio[5] = 3'd3; s2b_intr_core_id[5] = 2'd2; s2b_threshold[2] = 3'd1;
      irq_in[5] = 1'b1;
      step(5);
      checks++; if (external_int[2] !== 1'b1) begin errors++; $display("FAIL rst_pre got %b exp 1", external_int[2]); end
      claim_req[2] = 1'b1;
      @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++; if ({external_int, claim_ack, claim_valid} !== 12'h0) begin errors++; $display("FAIL rst_async_ctl got %h exp 0", {external_int, claim_ack, claim_valid}); end
      checks++; if ({b2s_intr_src, claim_id, b2s_pending} !== 72'h0) begin errors++; $display("FAIL rst_async_state got %h exp 0", {b2s_intr_src, claim_id, b2s_pending}); end
      step(1);
      claim_req[2] = 1'b0;
      step(1);
      rstn = 1'b1;
      step(2);
      checks++; if (external_int[2] !== 1'b0) begin errors++; $display("FAIL rst_resync_early got %b exp 0", external_int[2]); end
      step(2);
      checks++; if ({external_int[2], b2s_intr_src[2], b2s_pending[5]} !== {1'b1, 5'd5, 1'b1}) begin errors++; $display("FAIL rst_repend got %h exp 4b", {external_int[2], b2s_intr_src[2], b2s_pending[5]}); end
      checks++; if (b2s_pending[12] !== 1'b0) begin errors++; $display("FAIL rst_lost_state got %b exp 0", b2s_pending[12]); end
   endtask

   initial begin
      rstn             = 1'b0;
      irq_in           = '0;
      s2b_intr_core_id = '0;
      s2b_intr_en      = '0;
      s2b_dbg_en       = '0;
      s2b_intr_edge    = '0;
      s2b_intr_prio    = '0;
      s2b_threshold    = '0;
      claim_req        = '0;
      complete_req     = '0;
      complete_id      = '0;
      test_reset();
      test_level_claim();
      test_priority();
      test_threshold();
      test_edge();
      test_empty_claim_and_dbg();
      test_reset_mid_claim();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
